// File: rtl/conv_pkg.sv
// conv_pkg: shared output modes, reset kernel and accumulator sizing for the 3x3 convolution MAC
package conv_pkg;
  localparam logic [1:0] MODE_CONV = 2'd0;
  localparam logic [1:0] MODE_ABS = 2'd1;
  localparam logic [1:0] MODE_PASS = 2'd2;
  localparam int DEFAULT_KERNEL [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
  function automatic int acc_w(input int dw, input int cw);
    return dw + cw + 5;
  endfunction
endpackage

// File: rtl/conv_round_clamp.sv
// conv_round_clamp: rounding right-shift of the window sum followed by mode-dependent clamp to pixel range
module conv_round_clamp import conv_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W = 21,
  parameter int SHIFT_W = 4
) (
  input logic signed [ACC_W-1:0] sum,
  input logic [SHIFT_W-1:0] shift,
  input logic [1:0] mode,
  input logic [DATA_WIDTH-1:0] centre,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic sat
);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << DATA_WIDTH) - 1);
  logic signed [ACC_W:0] rnd, val, mag;
  always_comb begin
    rnd = (shift == '0) ? '0 : (ACC_W+1)'(1) << (shift - 1'b1);
    val = ($signed({sum[ACC_W-1], sum}) + rnd) >>> shift;
    mag = (mode == MODE_ABS && val < 0) ? -val : val;
    sat = mode != MODE_PASS && (mag < 0 || mag > MAXV);
    pixel = mode == MODE_PASS ? centre : mag < 0 ? '0 : mag > MAXV ? MAXV[DATA_WIDTH-1:0] : mag[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/conv3x3_mac_pipe.sv
// conv3x3_mac_pipe: 3-stage programmable 3x3 convolution MAC with rounding, clamp modes and valid/ready stall
module conv3x3_mac_pipe import conv_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int SHIFT_W = 4
) (
  input logic clk,
  input logic rst,
  input logic [9*DATA_WIDTH-1:0] in_pixel,
  input logic in_valid,
  output logic in_ready,
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic out_sat,
  output logic out_valid,
  input logic out_ready,
  input logic coef_we,
  input logic [3:0] coef_addr,
  input logic signed [COEF_WIDTH-1:0] coef_data,
  input logic [SHIFT_W-1:0] norm_shift,
  input logic [1:0] mode
);
  localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int AW = acc_w(DATA_WIDTH, COEF_WIDTH);
  logic signed [COEF_WIDTH-1:0] coef [9];
  logic signed [PW-1:0] prod [9];
  logic signed [PW-1:0] prod1 [9];
  logic signed [AW-1:0] sum, sum2;
  logic [DATA_WIDTH-1:0] centre1, centre2, pix3;
  logic [SHIFT_W-1:0] shift1, shift2;
  logic [1:0] mode1, mode2;
  logic v1, v2, sat3, en;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      prod[i] = $signed({{(PW-DATA_WIDTH){1'b0}}, in_pixel[i*DATA_WIDTH +: DATA_WIDTH]})
              * $signed({{(PW-COEF_WIDTH){coef[i][COEF_WIDTH-1]}}, coef[i]});
      sum = sum + {{(AW-PW){prod1[i][PW-1]}}, prod1[i]};
    end
  end
  conv_round_clamp #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(AW), .SHIFT_W(SHIFT_W)) u_rc (
    .sum(sum2), .shift(shift2), .mode(mode2), .centre(centre2), .pixel(pix3), .sat(sat3)
  );
  // Coefficient writes bypass the stall enable; stage data only needs its valid bit reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) coef[i] <= COEF_WIDTH'(DEFAULT_KERNEL[i]);
      {v1, v2, out_valid, out_sat} <= '0;
      out_pixel <= '0;
    end else begin
      for (int i = 0; i < 9; i++) if (coef_we && coef_addr == 4'(i)) coef[i] <= coef_data;
      if (en) begin
        v1 <= in_valid;
        prod1 <= prod;
        centre1 <= in_pixel[4*DATA_WIDTH +: DATA_WIDTH];
        shift1 <= norm_shift;
        mode1 <= mode;
        v2 <= v1;
        sum2 <= sum;
        centre2 <= centre1;
        shift2 <= shift1;
        mode2 <= mode1;
        out_valid <= v2;
        out_pixel <= pix3;
        out_sat <= sat3;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_mac_pipe.sv
// tb_conv3x3_mac_pipe: directed scoreboard bench for the 3x3 convolution MAC pipeline
module tb_conv3x3_mac_pipe;
  logic clk = 0, rst = 1;
  logic [71:0] in_pixel;
  logic in_valid, in_ready, out_sat, out_valid, out_ready, coef_we;
  logic [7:0] out_pixel;
  logic [3:0] coef_addr, norm_shift;
  logic signed [7:0] coef_data;
  logic [1:0] mode;
  int kc [9];
  logic [8:0] sb [$];
  int checks = 0, errors = 0;
  logic hold = 0;
  logic [8:0] held;

  conv3x3_mac_pipe dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .out_pixel(out_pixel), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .norm_shift(norm_shift), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [71:0] w, input logic [1:0] md, input logic [3:0] sh);
    longint s = 0;
    for (int i = 0; i < 9; i++) s += longint'(w[i*8 +: 8]) * kc[i];
    if (sh != 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (md == 2) return {1'b0, w[39:32]};
    if (md == 1 && s < 0) s = -s;
    if (s < 0) return 9'h100;
    if (s > 255) return 9'h1ff;
    return {1'b0, s[7:0]};
  endfunction

  function automatic logic [71:0] fill(input logic [7:0] c, input logic [7:0] o);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = (i == 4) ? c : o;
    return w;
  endfunction

  task automatic wr(input logic [3:0] a, input int d);
    coef_we = 1; coef_addr = a; coef_data = 8'(d);
    @(negedge clk);
    coef_we = 0;
    if (a < 9) kc[a] = d;
  endtask

  // Called at a negedge; acceptance is decided just before the rising edge.
  task automatic send(input logic [71:0] w, input logic [1:0] md, input logic [3:0] sh);
    int n = 0;
    in_pixel = w; mode = md; norm_shift = sh; in_valid = 1;
    #4;
    while (!in_ready && n < 50) begin
      @(negedge clk); #4; n++;
    end
    checks++;
    assert (in_ready) else begin
      errors++;
      $error("FAIL accept_timeout got=%0d exp=1", in_ready);
    end
    if (in_ready) sb.push_back(model(w, md, sh));
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_left got=%0d exp=0", sb.size());
    end
  endtask

  always begin
    @(negedge clk); #4;
    if (hold && !rst) chk("hold_stable", {out_valid, out_sat, out_pixel}, {1'b1, held});
    hold = out_valid && !out_ready && !rst;
    held = {out_sat, out_pixel};
    if (out_valid && out_ready && !rst) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out got=%0d exp=none", out_pixel);
      end
      if (sb.size() != 0) chk("out", {out_sat, out_pixel}, sb.pop_front());
    end
  end

  initial begin
    logic [71:0] w;
    kc = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    in_pixel = '0; in_valid = 0; out_ready = 1; coef_we = 0;
    coef_addr = 0; coef_data = 0; norm_shift = 0; mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_pixel", out_pixel, 0);
    chk("rst_sat", out_sat, 0);
    rst = 0;
    #4 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    // default sharpen kernel, latency 3
    send(fill(100, 100), 0, 0);
    chk("lat1", out_valid, 0);
    @(negedge clk) chk("lat2", out_valid, 0);
    @(negedge clk) chk("lat3", out_valid, 1);
    drain();
    send(fill(255, 0), 0, 0);
    send(fill(0, 255), 0, 0);
    send(fill(0, 255), 1, 0);
    send(fill(77, 200), 2, 0);
    send(fill(77, 200), 3, 0);
    drain();
    // programmable kernel with rounding shift
    for (int i = 0; i < 9; i++) wr(4'(i), 1);
    send(fill(80, 80), 0, 3);
    send(fill(1, 1), 0, 3);
    drain();
    wr(2, -7);
    // streaming with a 5-cycle downstream stall
    fork
      for (int k = 0; k < 8; k++) begin
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'($urandom);
        send(w, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 4)));
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 0;
        repeat (2) @(negedge clk);
        #4 chk("in_ready_stall", in_ready, 0);
        repeat (3) @(negedge clk);
        out_ready = 1;
      end
    join
    drain();
    // write in the accept cycle uses the old kernel; out-of-range address ignored
    coef_we = 1; coef_addr = 4; coef_data = 3;
    send(fill(10, 10), 0, 0);
    coef_we = 0; kc[4] = 3;
    send(fill(10, 10), 0, 0);
    wr(12, -50);
    send(fill(10, 10), 0, 0);
    drain();
    // reset with beats in flight
    send(fill(10, 20), 0, 0);
    send(fill(30, 40), 0, 0);
    send(fill(50, 60), 0, 0);
    rst = 1;
    @(negedge clk);
    chk("rst_flush_valid", out_valid, 0);
    sb.delete();
    rst = 0;
    kc = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    repeat (6) @(negedge clk);
    chk("no_stale", out_valid, 0);
    send(fill(100, 100), 0, 0);
    chk("lat1b", out_valid, 0);
    @(negedge clk) chk("lat2b", out_valid, 0);
    @(negedge clk) chk("lat3b", out_valid, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
